// File: rtl/conv_transpose2d.sv
// Transposed 2-D convolution (gather form): bias plus every valid tap product, saturated to DATA_WIDTH.
// Define CONVT_RELU_EN to clamp negative saturated results to zero before they are written.
module conv_transpose2d #(
  parameter int IN_CHANNELS    = 2,
  parameter int OUT_CHANNELS   = 2,
  parameter int IN_HEIGHT      = 2,
  parameter int IN_WIDTH       = 2,
  parameter int KERNEL_SIZE    = 3,
  parameter int STRIDE         = 2,
  parameter int PADDING        = 1,
  parameter int OUTPUT_PADDING = 1,
  parameter int DATA_WIDTH     = 8,
  parameter int ACC_WIDTH      = 20,
  parameter int ADDR_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] input_addr,
  output logic                  input_en,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  output logic                  weight_en,
  input  logic [DATA_WIDTH-1:0] weight_data,
  output logic [ADDR_WIDTH-1:0] output_addr,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_we
);

  localparam int OUT_HEIGHT = (IN_HEIGHT - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE + OUTPUT_PADDING;
  localparam int OUT_WIDTH  = (IN_WIDTH - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE + OUTPUT_PADDING;
  localparam int KK         = KERNEL_SIZE * KERNEL_SIZE;
  localparam int BIAS_BASE  = IN_CHANNELS * OUT_CHANNELS * KK;
  localparam int CW         = ADDR_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [2:0] {IDLE, BIAS_REQ, BIAS_WAIT, TAP, MAC, WRITE, DONE} state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                oc_q, oc_d, oy_q, oy_d, ox_q, ox_d;
  logic [CW-1:0]                ic_q, ic_d, ky_q, ky_d, kx_q, kx_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         busy_q, busy_d, done_q, done_d;
  logic                         input_en_q, input_en_d, weight_en_q, weight_en_d;
  logic                         output_we_q, output_we_d;
  logic [ADDR_WIDTH-1:0]        input_addr_q, input_addr_d, weight_addr_q, weight_addr_d;
  logic [ADDR_WIDTH-1:0]        output_addr_q, output_addr_d;
  logic [DATA_WIDTH-1:0]        output_data_q, output_data_d;

  logic                         advance, last_tap, last_pix, vy, vx, fetch;
  logic [CW-1:0]                iy_n, ix_n;
  logic signed [2*DATA_WIDTH-1:0] prod;

  // A tap contributes only when the un-strided coordinate lands exactly on an input sample.
  function automatic logic tap_ok(input logic [CW-1:0] o, input logic [CW-1:0] k,
                                  input int lim, output logic [CW-1:0] idx);
    int t;
    t   = int'(o) + PADDING - int'(k);
    idx = CW'(t / STRIDE);
    return (t >= 0) && (t % STRIDE == 0) && (t / STRIDE < lim);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] r;
    if (a > SAT_MAX)      r = SAT_MAX[DATA_WIDTH-1:0];
    else if (a < SAT_MIN) r = SAT_MIN[DATA_WIDTH-1:0];
    else                  r = a[DATA_WIDTH-1:0];
`ifdef CONVT_RELU_EN
    if (r[DATA_WIDTH-1]) r = '0;
`endif
    return r;
  endfunction

  assign prod     = $signed(input_data) * $signed(weight_data);
  assign last_tap = (ic_q == CW'(IN_CHANNELS - 1)) && (ky_q == CW'(KERNEL_SIZE - 1)) &&
                    (kx_q == CW'(KERNEL_SIZE - 1));
  assign last_pix = (oc_q == CW'(OUT_CHANNELS - 1)) && (oy_q == CW'(OUT_HEIGHT - 1)) &&
                    (ox_q == CW'(OUT_WIDTH - 1));

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    oc_d    = oc_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    ic_d    = ic_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    acc_d   = acc_q;
    advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BIAS_REQ;
          oc_d    = '0;
          oy_d    = '0;
          ox_d    = '0;
          ic_d    = '0;
          ky_d    = '0;
          kx_d    = '0;
          acc_d   = '0;
        end
      end
      BIAS_REQ:  state_d = BIAS_WAIT;
      BIAS_WAIT: begin
        acc_d   = ACC_WIDTH'($signed(weight_data));
        state_d = TAP;
      end
      // The registered fetch strobe already tells whether the current tap is valid.
      TAP: begin
        if (input_en_q) state_d = MAC;
        else            advance = 1'b1;
      end
      MAC: begin
        acc_d   = acc_q + ACC_WIDTH'(prod);
        advance = 1'b1;
      end
      WRITE: begin
        if (last_pix) begin
          state_d = DONE;
        end else begin
          state_d = BIAS_REQ;
          if (ox_q == CW'(OUT_WIDTH - 1)) begin
            ox_d = '0;
            if (oy_q == CW'(OUT_HEIGHT - 1)) begin
              oy_d = '0;
              oc_d = oc_q + 1'b1;
            end else begin
              oy_d = oy_q + 1'b1;
            end
          end else begin
            ox_d = ox_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (last_tap) begin
        ic_d    = '0;
        ky_d    = '0;
        kx_d    = '0;
        state_d = WRITE;
      end else begin
        state_d = TAP;
        if (kx_q == CW'(KERNEL_SIZE - 1)) begin
          kx_d = '0;
          if (ky_q == CW'(KERNEL_SIZE - 1)) begin
            ky_d = '0;
            ic_d = ic_q + 1'b1;
          end else begin
            ky_d = ky_q + 1'b1;
          end
        end else begin
          kx_d = kx_q + 1'b1;
        end
      end
    end

    // Strobes and addresses are registered, so they are derived from the next state and counters.
    vy    = tap_ok(oy_d, ky_d, IN_HEIGHT, iy_n);
    vx    = tap_ok(ox_d, kx_d, IN_WIDTH, ix_n);
    fetch = (state_d == TAP) && vy && vx;

    busy_d        = (state_d != IDLE) && (state_d != DONE);
    done_d        = (state_d == DONE);
    input_en_d    = fetch;
    weight_en_d   = fetch || (state_d == BIAS_REQ);
    output_we_d   = (state_d == WRITE);
    input_addr_d  = input_addr_q;
    weight_addr_d = weight_addr_q;
    output_addr_d = output_addr_q;
    output_data_d = output_data_q;

    if (fetch) begin
      input_addr_d  = ADDR_WIDTH'(int'(ic_d) * IN_HEIGHT * IN_WIDTH + int'(iy_n) * IN_WIDTH + int'(ix_n));
      weight_addr_d = ADDR_WIDTH'(int'(ic_d) * OUT_CHANNELS * KK + int'(oc_d) * KK +
                                  int'(ky_d) * KERNEL_SIZE + int'(kx_d));
    end
    if (state_d == BIAS_REQ) weight_addr_d = ADDR_WIDTH'(BIAS_BASE + int'(oc_d));
    if (output_we_d) begin
      output_addr_d = ADDR_WIDTH'(int'(oc_d) * OUT_HEIGHT * OUT_WIDTH + int'(oy_d) * OUT_WIDTH + int'(ox_d));
      output_data_d = saturate(acc_d);
    end
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      oc_q          <= '0;
      oy_q          <= '0;
      ox_q          <= '0;
      ic_q          <= '0;
      ky_q          <= '0;
      kx_q          <= '0;
      acc_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      input_en_q    <= 1'b0;
      weight_en_q   <= 1'b0;
      output_we_q   <= 1'b0;
      input_addr_q  <= '0;
      weight_addr_q <= '0;
      output_addr_q <= '0;
      output_data_q <= '0;
    end else begin
      state_q       <= state_d;
      oc_q          <= oc_d;
      oy_q          <= oy_d;
      ox_q          <= ox_d;
      ic_q          <= ic_d;
      ky_q          <= ky_d;
      kx_q          <= kx_d;
      acc_q         <= acc_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      input_en_q    <= input_en_d;
      weight_en_q   <= weight_en_d;
      output_we_q   <= output_we_d;
      input_addr_q  <= input_addr_d;
      weight_addr_q <= weight_addr_d;
      output_addr_q <= output_addr_d;
      output_data_q <= output_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign input_en    = input_en_q;
  assign weight_en   = weight_en_q;
  assign output_we   = output_we_q;
  assign input_addr  = input_addr_q;
  assign weight_addr = weight_addr_q;
  assign output_addr = output_addr_q;
  assign output_data = output_data_q;

endmodule

// File: tb/tb_conv_transpose2d.sv
// Directed bench for conv_transpose2d at default parameters: values, ordering, latency, reset, start handling.
`timescale 1ns/1ps
module tb_conv_transpose2d;
  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int NPIX = 32;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, input_en, weight_en, output_we;
  logic [AW-1:0] input_addr, weight_addr, output_addr;
  logic [DW-1:0] input_data, weight_data, output_data;

  always #5 clk = ~clk;

  conv_transpose2d dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .input_addr  (input_addr),
    .input_en    (input_en),
    .input_data  (input_data),
    .weight_addr (weight_addr),
    .weight_en   (weight_en),
    .weight_data (weight_data),
    .output_addr (output_addr),
    .output_data (output_data),
    .output_we   (output_we)
  );

  logic [DW-1:0] in_mem [256];
  logic [DW-1:0] w_mem  [256];

  always @(posedge clk) begin
    if (input_en)  input_data  <= in_mem[input_addr];
    if (weight_en) weight_data <= w_mem[weight_addr];
  end

  int                   cyc = 0, wr_n = 0, done_n = 0, in_en_n = 0, w_en_n = 0;
  int                   orphan_n = 0, busy_done_n = 0, rise_cyc = 0, done_cyc = 0;
  logic                 busy_prev = 1'b0;
  logic [AW-1:0]        wr_addr [1024];
  logic signed [DW-1:0] wr_data [1024];
  int                   wr_cyc  [1024];

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    busy_prev <= busy;
    if (busy && !busy_prev) rise_cyc <= cyc;
    if (output_we && wr_n < 1024) begin
      wr_addr[wr_n] <= output_addr;
      wr_data[wr_n] <= output_data;
      wr_cyc[wr_n]  <= cyc;
      wr_n          <= wr_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
      if (busy) busy_done_n <= busy_done_n + 1;
    end
    if (input_en)              in_en_n  <= in_en_n + 1;
    if (weight_en)             w_en_n   <= w_en_n + 1;
    if (input_en && !weight_en) orphan_n <= orphan_n + 1;
  end

  int total = 0;
  int bad   = 0;
  // Valid kernel positions per output row (and column) at the default geometry.
  int cnt_axis [4] = '{1, 2, 1, 1};

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_ones(input int a, input int b0, input int b1);
    int p;
    p = a % 16;
    return 2 * cnt_axis[p / 4] * cnt_axis[p % 4] + ((a / 16) == 1 ? b1 : b0);
  endfunction

  task automatic load(input int iv, input int wv, input int b0, input int b1);
    for (int a = 0; a < 256; a++) begin
      in_mem[a] = (a < 8)  ? DW'(iv) : '0;
      w_mem[a]  = (a < 36) ? DW'(wv) : '0;
    end
    w_mem[36] = DW'(b0);
    w_mem[37] = DW'(b1);
  endtask

  task automatic run_pass(input string tag, input int poke, output int base);
    int d0, order_err;
    base = wr_n;
    d0   = done_n;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 4000 && done_n == d0; i++) begin
      @(posedge clk); #1 start = (i == poke);
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_done_cnt"}, done_n - d0, 1);
    check({tag, "_nwr"}, wr_n - base, NPIX);
    check({tag, "_busy_after"}, int'(busy), 0);
    order_err = 0;
    for (int a = 0; a < NPIX; a++) if (wr_addr[base + a] !== AW'(a)) order_err++;
    check({tag, "_order"}, order_err, 0);
    check({tag, "_done_after_last_wr"}, done_cyc, wr_cyc[base + NPIX - 1] + 1);
    check({tag, "_busy_during_done"}, busy_done_n, 0);
  endtask

  initial begin
    int b, d0, e0, w0, hit, neg_exp, order_err;
`ifdef CONVT_RELU_EN
    neg_exp = 0;
`else
    neg_exp = -128;
`endif
    load(1, 1, 0, 0);
    #2 rst = 1'b0;
    #10;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_input_en", int'(input_en), 0);
    check("rst_weight_en", int'(weight_en), 0);
    check("rst_output_we", int'(output_we), 0);
    check("rst_input_addr", int'(input_addr), 0);
    check("rst_weight_addr", int'(weight_addr), 0);
    check("rst_output_addr", int'(output_addr), 0);
    check("rst_output_data", int'(output_data), 0);
    @(negedge clk) rst = 1'b1;

    e0 = in_en_n;
    w0 = w_en_n;
    run_pass("ones", -1, b);
    for (int a = 0; a < NPIX; a++) check($sformatf("ones_px%0d", a), wr_data[b + a], exp_ones(a, 0, 0));
    check("lat_px0", wr_cyc[b] - rise_cyc + 1, 23);
    check("in_en_cnt", in_en_n - e0, 100);
    check("w_en_cnt", w_en_n - w0, 132);
    check("in_en_orphan", orphan_n, 0);

    w_mem[37] = 8'd5;
    run_pass("bias1", -1, b);
    for (int a = 0; a < NPIX; a++) check($sformatf("bias_px%0d", a), wr_data[b + a], exp_ones(a, 0, 5));
    check("bias_addr16", wr_data[b + 16], 7);

    load(127, 127, 0, 0);
    run_pass("satp", -1, b);
    check("satp_px5", wr_data[b + 5], 127);
    check("satp_px0", wr_data[b + 0], 127);
    check("satp_px21", wr_data[b + 21], 127);

    load(-128, 127, 0, 0);
    run_pass("satn", -1, b);
    check("satn_px5", wr_data[b + 5], neg_exp);
    check("satn_px0", wr_data[b + 0], neg_exp);

    load(1, 1, 0, 0);
    run_pass("poke", 60, b);
    check("poke_px31", wr_data[b + 31], exp_ones(31, 0, 0));

    b = wr_n;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 2000 && wr_n < b + 2; i++) @(posedge clk);
    hit = 0;
    for (int i = 0; i < 200 && hit == 0; i++) begin
      @(posedge clk); #1 hit = int'(input_en);
    end
    check("rst_reach_tap", hit, 1);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("midrst_input_en", int'(input_en), 0);
    check("midrst_weight_en", int'(weight_en), 0);
    check("midrst_output_we", int'(output_we), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_weight_addr", int'(weight_addr), 0);
    check("midrst_output_data", int'(output_data), 0);
    check("midrst_nwr", wr_n - b, 2);
    @(negedge clk) rst = 1'b1;
    run_pass("after_rst", -1, b);
    check("after_rst_first_addr", int'(wr_addr[b]), 0);
    for (int a = 0; a < NPIX; a++) check($sformatf("after_rst_px%0d", a), wr_data[b + a], exp_ones(a, 0, 0));

    d0 = done_n;
    b  = wr_n;
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < 8000 && done_n < d0 + 2; i++) @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("b2b_done_cnt", done_n - d0, 2);
    check("b2b_nwr", wr_n - b, 2 * NPIX);
    check("b2b_busy_after", int'(busy), 0);
    order_err = 0;
    for (int a = 0; a < 2 * NPIX; a++) if (wr_addr[b + a] !== AW'(a % NPIX)) order_err++;
    check("b2b_order", order_err, 0);
    check("b2b_px37", wr_data[b + 37], exp_ones(5, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_transpose2d.md
Name: conv_transpose2d

Overview:
- Transposed 2-D convolution (learned upsampling) for the synthesis/decoder path. It is the inverse-direction partner of the stride-2 downsampling conv2d used on the analysis side.
- Gather formulation: for each output pixel it sums every contributing input tap times its weight, adds bias, then clamps.
- Reads activations and weights through single-port synchronous memory interfaces. Writes results to an output memory. Batch size is 1.

Parameters:
- IN_CHANNELS, 2, input feature channels (IC)
- OUT_CHANNELS, 2, output feature channels (OC)
- IN_HEIGHT, 2, input rows (IH)
- IN_WIDTH, 2, input columns (IW)
- KERNEL_SIZE, 3, square kernel size (K)
- STRIDE, 2, upsampling stride (S), 1..4
- PADDING, 1, transposed-conv padding (P)
- OUTPUT_PADDING, 1, extra rows/cols at bottom/right (OP), OP < S
- DATA_WIDTH, 8, signed activation/weight/bias width
- ACC_WIDTH, 20, signed accumulator width
- ADDR_WIDTH, 8, width of every memory address port

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a full layer pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse when the last output has been written
- input_addr  out  ADDR_WIDTH  activation read address
- input_en  out  1  activation read strobe
- input_data  in  DATA_WIDTH  activation, valid the cycle after input_en
- weight_addr  out  ADDR_WIDTH  weight/bias read address
- weight_en  out  1  weight read strobe
- weight_data  in  DATA_WIDTH  weight/bias, valid the cycle after weight_en
- output_addr  out  ADDR_WIDTH  result write address
- output_data  out  DATA_WIDTH  result
- output_we  out  1  one-cycle write strobe

Behaviour:
- Output size: OH = (IH-1)*S - 2P + K + OP, and likewise for OW. Defaults give 4x4.
- Memory layouts:
  - Input address = ic*IH*IW + iy*IW + ix.
  - Weight address = ic*OC*K*K + oc*K*K + ky*K + kx, i.e. [in][out][ky][kx].
  - Bias for channel oc is at weight address IC*OC*K*K + oc.
  - Output address = oc*OH*OW + oy*OW + ox.
- Loop order, outer to inner: oc, oy, ox (output pixels); ic, ky, kx (taps).
- Tap validity: ty = oy + P - ky and tx = ox + P - kx, both signed.
  - A tap is valid iff ty >= 0, ty % S == 0, ty/S < IH, and the same holds for tx.
  - Then iy = ty/S and ix = tx/S.
- States:
  - IDLE: on start, clear counters and go to BIAS_REQ.
  - BIAS_REQ: assert weight_en at the bias address; go to BIAS_WAIT.
  - BIAS_WAIT: acc <= sign-extended weight_data; go to TAP.
  - TAP, invalid tap: no strobes; advance the tap counters. Go to WRITE after the last tap, otherwise stay in TAP.
  - TAP, valid tap: assert input_en and weight_en together with their addresses; go to MAC.
  - MAC: acc <= acc + input_data*weight_data (signed, full product sign-extended); advance the tap counters; go to TAP, or WRITE after the last tap.
  - WRITE: output_we=1 with output_addr and clamp(acc).
    - If this is the last pixel of the last channel, go to DONE; otherwise advance ox/oy/oc and go to BIAS_REQ.
  - DONE: done=1 for one cycle; go to IDLE.
- Latency per output pixel = 3 + (number of invalid taps) + 2*(number of valid taps) cycles.
- Clamp: signed saturation of acc to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. ACC_WIDTH is sized by the integrator so acc never wraps.
- Strobes (input_en, weight_en, output_we) are single-cycle. Addresses and output_data are registered and hold their value when not strobed.
- start while busy is ignored. start held high after DONE begins a new pass from IDLE.
- Reset: asserting rst low at any time, including mid-pass, immediately sets:
  - state=IDLE; busy=0, done=0, input_en=0, weight_en=0, output_we=0
  - all addresses=0, output_data=0; acc and counters=0.
- Rows/columns that receive no valid tap (OP region) are written as clamp(bias).

Optional Feature:
- Macro CONVT_RELU_EN.
- Defined: after saturation, negative results are written as 0 (fused ReLU); everything else is unchanged.
- Undefined: the saturated signed result is written as-is.

Test Plan:
- Defaults, all inputs=1, all weights=1, bias=0, start pulse:
  - 32 writes in order oc, oy, ox; channel 0 row 0 = 2,4,2,2; row 1 = 4,8,4,4.
  - done pulses once, the cycle after the last write; busy falls with it.
- Same data, bias[1]=5: channel 1 values are 5 higher than channel 0; address 16 holds 7.
- All inputs=127, weights=127: pixel (1,1) saturates to 127.
  - All inputs=-128, weights=127: pixel (1,1) writes -128, or 0 with CONVT_RELU_EN.
- Cycle count: pixel (0,0) takes 3 + 16 invalid + 2*2 valid = 23 cycles from BIAS_REQ to WRITE.
  - No input_en is asserted for invalid taps.
- Drop rst low during the third pixel's MAC: all strobes are low within the same cycle, busy=0.
  - After release, a new start rewrites from address 0.
- Pulse start while busy: no restart and no extra done. Hold start high: back-to-back passes, one done each.
